// File: rtl/msg_window_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msg_pkg
//  Description : Shared defaults, character type and direction codes for the
//                rotating message window reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package msg_pkg;

  localparam int CHAR_W_DEF  = 4;
  localparam int MSG_LEN_DEF = 16;
  localparam int DIGITS_DEF  = 4;

  typedef logic [CHAR_W_DEF-1:0] char_t;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

endpackage
`default_nettype wire

// File: rtl/msg_window_reader_pos_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : msg_pos_ctr
//  Description : Start-position counter for the message window. Holds the
//                active message length, advances forward/backward with
//                wrap-around and emits a one-cycle wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_pos_ctr
  import msg_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int AW      = $clog2(MSG_LEN),
  parameter int LW      = $clog2(MSG_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  input  logic          dir,
  input  logic          len_wr,
  input  logic [LW-1:0] len_data,
  output logic [AW-1:0] pos,
  output logic [LW-1:0] msg_len,
  output logic          wrap_p
);

  logic          w_len_ok;
  logic [LW-1:0] w_eff_len;
  logic [LW-1:0] w_last;
  logic [LW-1:0] w_pos_ext;
  logic [AW-1:0] w_pos_nxt;
  logic          w_wrap_nxt;

  // A length load is honoured only for 1..MSG_LEN; the wrap check of a
  // coincident advance already uses the new length.
  assign w_len_ok  = len_wr && (len_data != '0) && (len_data <= LW'(MSG_LEN));
  assign w_eff_len = w_len_ok ? len_data : msg_len;
  assign w_last    = w_eff_len - LW'(1);
  assign w_pos_ext = LW'(pos);

  // Next position: shrinking the length below pos forces 0 and beats advance.
  always_comb begin
    w_pos_nxt  = pos;
    w_wrap_nxt = 1'b0;
    if (w_len_ok && (w_pos_ext >= len_data)) begin
      w_pos_nxt = '0;
    end else if (adv) begin
      if (dir == DIR_BWD) begin
        if (pos == '0) begin
          w_pos_nxt  = AW'(w_last);
          w_wrap_nxt = 1'b1;
        end else begin
          w_pos_nxt = pos - AW'(1);
        end
      end else begin
        if (w_pos_ext == w_last) begin
          w_pos_nxt  = '0;
          w_wrap_nxt = 1'b1;
        end else begin
          w_pos_nxt = pos + AW'(1);
        end
      end
    end
  end

  // Position, length and wrap pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos     <= '0;
      msg_len <= LW'(MSG_LEN);
      wrap_p  <= 1'b0;
    end else begin
      pos    <= w_pos_nxt;
      wrap_p <= w_wrap_nxt;
      if (w_len_ok) begin
        msg_len <= len_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/msg_window_reader.sv
`default_nettype none
// ============================================================================
//  Module      : msg_window_reader
//  Description : Runtime-loadable rotating message store presenting a
//                registered window of DIGITS consecutive characters, with an
//                internal position counter (step / auto-run, direction).
//  Revision    : 1.0 - initial release
// ============================================================================
module msg_window_reader
  import msg_pkg::*;
#(
  parameter int CHAR_W  = CHAR_W_DEF,
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter int AW      = $clog2(MSG_LEN),
  parameter int LW      = $clog2(MSG_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [CHAR_W-1:0]        wr_data,
  input  logic                     len_wr,
  input  logic [LW-1:0]            len_data,
  input  logic                     step,
  input  logic                     run,
  input  logic                     tick,
  input  logic                     dir,
  output logic [DIGITS*CHAR_W-1:0] window,
  output logic [AW-1:0]            pos,
  output logic [LW-1:0]            msg_len,
  output logic                     wrap_p
);

  logic [CHAR_W-1:0]        r_mem [MSG_LEN];
  logic                     w_adv;
  logic [DIGITS*CHAR_W-1:0] w_win_next;
  logic [AW-1:0]            w_idx;

  // A step and a tick in the same cycle collapse into a single advance.
  assign w_adv = step | (run & tick);

  msg_pos_ctr #(
    .MSG_LEN (MSG_LEN),
    .AW      (AW),
    .LW      (LW)
  ) u_pos_ctr (
    .clk      (clk),
    .reset    (reset),
    .adv      (w_adv),
    .dir      (dir),
    .len_wr   (len_wr),
    .len_data (len_data),
    .pos      (pos),
    .msg_len  (msg_len),
    .wrap_p   (wrap_p)
  );

  // Message store: identity pattern on reset, single-character writes after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_mem[i] <= CHAR_W'(i);
      end
    end else if (wr_en && (LW'(wr_addr) < LW'(MSG_LEN))) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Walk the index from pos, wrapping at msg_len, so short messages repeat.
  always_comb begin
    w_win_next = '0;
    w_idx      = pos;
    for (int k = 0; k < DIGITS; k++) begin
      w_win_next[(DIGITS-1-k)*CHAR_W +: CHAR_W] = r_mem[w_idx];
      w_idx = (LW'(w_idx) == (msg_len - LW'(1))) ? '0 : (w_idx + AW'(1));
    end
  end

  // Window register: one cycle behind pos/mem, no input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DIGITS; k++) begin
        window[(DIGITS-1-k)*CHAR_W +: CHAR_W] <= CHAR_W'(k % MSG_LEN);
      end
    end else begin
      window <= w_win_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_window_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msg_window_reader
//  Description : Self-checking bench for msg_window_reader against a
//                behavioural message/position model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_window_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  wr_data = '0;
  logic        len_wr = 1'b0;
  logic [4:0]  len_data = '0;
  logic        step = 1'b0;
  logic        run = 1'b0;
  logic        tick = 1'b0;
  logic        dir = 1'b0;
  logic [15:0] window;
  logic [3:0]  pos;
  logic [4:0]  msg_len;
  logic        wrap_p;

  int vectors = 0;
  int miscompares = 0;

  int m_mem [16];
  int m_pos;
  int m_len;
  int m_wrap;

  msg_window_reader dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .len_wr   (len_wr),
    .len_data (len_data),
    .step     (step),
    .run      (run),
    .tick     (tick),
    .dir      (dir),
    .window   (window),
    .pos      (pos),
    .msg_len  (msg_len),
    .wrap_p   (wrap_p)
  );

  always #5 clk = ~clk;

  function automatic int model_window();
    int w;
    w = 0;
    for (int k = 0; k < 4; k++) begin
      w = w * 16 + m_mem[(m_pos + k) % m_len];
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = i;
    m_pos  = 0;
    m_len  = 16;
    m_wrap = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply the currently driven inputs for one clock and check everything.
  task automatic clock_cycle(input string tag);
    int exp_win;
    bit adv;
    bit lok;
    exp_win = model_window();
    adv = step | (run & tick);
    lok = len_wr && (len_data >= 1) && (len_data <= 16);
    if (wr_en) m_mem[wr_addr] = int'(wr_data);
    m_wrap = 0;
    if (lok) m_len = int'(len_data);
    if (lok && (m_pos >= m_len)) begin
      m_pos = 0;
    end else if (adv) begin
      if (dir == 1'b0) begin
        if (m_pos + 1 >= m_len) m_wrap = 1;
        m_pos = (m_pos + 1) % m_len;
      end else begin
        if (m_pos == 0) m_wrap = 1;
        m_pos = (m_pos + m_len - 1) % m_len;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, ".pos"},     32'(pos),     32'(m_pos));
    chk({tag, ".msg_len"}, 32'(msg_len), 32'(m_len));
    chk({tag, ".wrap_p"},  32'(wrap_p),  32'(m_wrap));
    chk({tag, ".window"},  32'(window),  32'(exp_win));
    step   = 1'b0;
    tick   = 1'b0;
    wr_en  = 1'b0;
    len_wr = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".pos"},     32'(pos),     32'h0);
    chk({tag, ".msg_len"}, 32'(msg_len), 32'd16);
    chk({tag, ".wrap_p"},  32'(wrap_p),  32'h0);
    chk({tag, ".window"},  32'(window),  32'h0123);
  endtask

  initial begin
    model_reset();
    // Power-on reset.
    #2 reset = 1'b0;
    #2 chk_reset_values("por");
    @(posedge clk);
    #1 chk_reset_values("por_held");
    reset = 1'b1;
    clock_cycle("idle0");
    clock_cycle("idle1");

    // Sixteen forward steps, then one idle to see the final window.
    dir = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step = 1'b1;
      clock_cycle("fwd16");
    end
    clock_cycle("fwd16_tail");
    chk("fwd16.final_window", 32'(window), 32'h0123);

    // Backward across the wrap boundary.
    dir = 1'b1;
    step = 1'b1;
    clock_cycle("bwd_wrap");
    clock_cycle("bwd_wrap_idle");
    chk("bwd.window_F012", 32'(window), 32'hF012);
    step = 1'b1;
    clock_cycle("bwd2");
    clock_cycle("bwd2_idle");
    chk("bwd.window_EF01", 32'(window), 32'hEF01);

    // Move to pos 7, then shrink the length to 5.
    dir = 1'b0;
    for (int i = 0; i < 20 && m_pos != 7; i++) begin
      step = 1'b1;
      clock_cycle("to_pos7");
    end
    chk("pos_is_7", 32'(pos), 32'd7);
    len_wr = 1'b1; len_data = 5'd5;
    clock_cycle("len5");
    for (int i = 0; i < 5; i++) begin
      step = 1'b1;
      clock_cycle("len5_step");
    end
    clock_cycle("len5_tail");
    len_wr = 1'b1; len_data = 5'd0;
    clock_cycle("len0_ignored");
    len_wr = 1'b1; len_data = 5'd17;
    clock_cycle("len17_ignored");

    // Auto-run with ticks every third cycle, one coincident step.
    run = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick = (c % 3 == 0);
      step = (c == 3);
      clock_cycle("run_tick");
    end
    run = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick = (c % 3 == 0);
      clock_cycle("run_off_tick");
    end

    // Write a displayed character together with a step.
    len_wr = 1'b1; len_data = 5'd16;
    clock_cycle("len16");
    for (int i = 0; i < 20 && m_pos != 1; i++) begin
      step = 1'b1;
      clock_cycle("to_pos1");
    end
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 4'hA; step = 1'b1;
    clock_cycle("wr_step");
    clock_cycle("wr_step_tail");
    chk("wr_step.window_A345", 32'(window), 32'hA345);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      wr_en    = ($urandom % 4) == 0;
      wr_addr  = 4'($urandom);
      wr_data  = 4'($urandom);
      len_wr   = ($urandom % 12) == 0;
      len_data = 5'($urandom_range(0, 19));
      step     = ($urandom % 3) == 0;
      run      = 1'($urandom);
      tick     = 1'($urandom);
      dir      = 1'($urandom);
      clock_cycle("rand");
    end

    // Mid-rotation asynchronous reset.
    len_wr = 1'b1; len_data = 5'd16; dir = 1'b0;
    clock_cycle("pre_rst_len");
    run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick = 1'b1;
      clock_cycle("pre_rst_run");
    end
    run = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset_values("mid_rst");
    model_reset();
    @(posedge clk);
    #1 chk_reset_values("mid_rst_held");
    reset = 1'b1;
    clock_cycle("post_rst_idle");
    for (int i = 0; i < 16; i++) begin
      step = 1'b1;
      clock_cycle("post_rst_fwd");
    end
    clock_cycle("post_rst_tail");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msg_window_reader.md
Name: msg_window_reader

Overview:
- Stores a rotating message of up to MSG_LEN characters and presents a sliding window of DIGITS consecutive characters to the 7-segment display driver.
- Successor to the fixed 16-char/4-digit reader, which needed an external position counter.
- Adds a runtime-loadable message, runtime message length, and an internal position counter with direction control and auto-run.
- Sits between the button/tick logic and the digit multiplexer/decoder.

Parameters:
- CHAR_W, 4, bits per character code.
- MSG_LEN, 16, message memory depth (≥2).
- DIGITS, 4, window width in characters (1..MSG_LEN).
- AW, $clog2(MSG_LEN), address/position width.
- LW, $clog2(MSG_LEN+1), length field width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write one message character this cycle
- wr_addr  in  AW  character index (≥MSG_LEN ignored)
- wr_data  in  CHAR_W  character code
- len_wr  in  1  load new active message length
- len_data  in  LW  new length (valid 1..MSG_LEN; other values ignored)
- step  in  1  single-cycle advance request (debounced button pulse)
- run  in  1  auto-rotate enable
- tick  in  1  rotation-rate strobe; used only when run=1
- dir  in  1  0 = forward (pos+1), 1 = backward (pos-1)
- window  out  DIGITS*CHAR_W  displayed characters; MS slice = leftmost digit
- pos  out  AW  current start position
- msg_len  out  LW  active length
- wrap_p  out  1  one-cycle pulse when pos crosses the wrap boundary

Behaviour:
- Reset (reset=0, asynchronous):
  - mem[i] = i mod 2^CHAR_W.
  - pos = 0, msg_len = MSG_LEN, wrap_p = 0.
  - window = mem[0..DIGITS-1] (leftmost = mem[0]).
- Advance request: adv = step | (run & tick). Coincident step and tick produce exactly one advance.
- Position update on the clock edge where adv=1:
  - Forward: pos_n = (pos == msg_len-1) ? 0 : pos+1.
  - Backward: pos_n = (pos == 0) ? msg_len-1 : pos-1.
- wrap_p = 1 for the cycle following an edge where a wrap occurred (forward from msg_len-1, or backward from 0), otherwise 0.
- msg_len = 1: pos stays 0 and every advance asserts wrap_p.
- Length load (len_wr with a valid value):
  - msg_len takes the new value at the edge.
  - If pos ≥ new length, pos is forced to 0. This takes priority over a coincident advance, and wrap_p is not asserted.
  - Otherwise, a coincident advance uses the new length for its wrap check.
- Memory write: mem[wr_addr] <= wr_data at the edge. Writes outside 0..msg_len-1 (but < MSG_LEN) are stored and become visible if the length is later increased.
- Window register, loaded every clock from the current mem and pos registers: window digit k (k=0 leftmost) = mem[(pos+k) mod msg_len].
  - If DIGITS > msg_len, characters repeat cyclically.
- Latency:
  - An input sampled at edge N updates pos/mem/msg_len at edge N; window reflects it at edge N+1.
  - pos and msg_len outputs change at edge N.
- Same-cycle write to a displayed character plus advance: both take effect at edge N; window at N+1 shows the new character in the new position.
- dir is sampled only with adv; changing dir without adv has no effect.
- Reset asserted mid-operation overrides everything immediately, and the message contents revert to the identity pattern.
- No combinational path from inputs to outputs.

Decomposition:
- Package msg_pkg holds:
  - Default constants CHAR_W_DEF=4, MSG_LEN_DEF=16, DIGITS_DEF=4.
  - A typedef char_t (CHAR_W_DEF bits).
  - DIR_FWD/DIR_BWD constants.
- Sub-module msg_pos_ctr owns pos, msg_len, the wrap logic and wrap_p (inputs adv, dir, len_wr, len_data).
- Memory and window mux stay in the top module.

Test Plan:
- Reset release, no inputs -> window=0x0123, pos=0, msg_len=16, wrap_p=0.
- 16 step pulses, dir=0 -> windows 0x1234, 0x2345 … 0xF012, then 0x0123; wrap_p high exactly once, after the 16th edge; window lags pos by one cycle.
- From pos=0, step with dir=1 -> pos=15, wrap_p pulse, window=0xF012; next step -> pos=14, window=0xEF01.
- len_wr=5 with pos=7 -> pos=0, no wrap_p; 5 forward steps -> window sequence 0x1234, 0x2340, 0x3401, 0x4012, 0x0123, with wrap_p on the 5th step; len_data=0 or 17 -> ignored.
- run=1 with ticks every 3 cycles, plus step coincident with one tick -> exactly one advance per tick; run=0 ignores ticks.
- Write mem[2]=0xA coincident with a step at pos=1 -> next-next window=0xA345; assert reset mid-rotation -> immediate return to reset values and identity contents.
